// File: rtl/register_file_param.sv
// register_file_param
//
// Parameterised register file with two registered read ports, one
// combinational debug read port and one byte-masked write port.
// After reset the array is swept once, one entry per clock, writing the
// init value (SP_RESET into entry SP_INDEX, zero elsewhere). Writes are
// refused while the sweep runs, and each refusal is flagged with a
// one-cycle write_dropped pulse.
//
// Ports:
//   clock              rising-edge clock
//   reset              synchronous active-high reset
//   read_address_1/2   read port addresses (data_out_1/2 one cycle later)
//   write_address      write address
//   write_data_in      write data
//   write_enable       write strobe
//   write_byte_enable  per-byte write mask (bit b covers data bits 8b+7:8b)
//   read_address_debug debug read address
//   data_out_1/2       registered read data, same-cycle write bypassed
//   data_out_debug     combinational read of the array (0 while sweeping)
//   ready              1 once the initialisation sweep has finished
//   write_dropped      one-cycle pulse after a write refused during the sweep

module register_file_param #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 5,
    parameter int          SP_INDEX   = 29,
    parameter logic [31:0] SP_RESET   = 32'h000000FC,
    parameter int          ZERO_REG   = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   read_address_1,
    input  logic [ADDR_WIDTH-1:0]   read_address_2,
    input  logic [ADDR_WIDTH-1:0]   write_address,
    input  logic [DATA_WIDTH-1:0]   write_data_in,
    input  logic                    write_enable,
    input  logic [DATA_WIDTH/8-1:0] write_byte_enable,
    input  logic [ADDR_WIDTH-1:0]   read_address_debug,
    output logic [DATA_WIDTH-1:0]   data_out_1,
    output logic [DATA_WIDTH-1:0]   data_out_2,
    output logic [DATA_WIDTH-1:0]   data_out_debug,
    output logic                    ready,
    output logic                    write_dropped
);

    localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
    localparam int                    NBYTES    = DATA_WIDTH / 8;
    localparam bit                    HARD_ZERO = (ZERO_REG != 0);
    localparam logic [ADDR_WIDTH-1:0] SP_ADDR   = ADDR_WIDTH'(SP_INDEX);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = '1;
    localparam logic [DATA_WIDTH-1:0] SP_INIT   = DATA_WIDTH'(SP_RESET);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [ADDR_WIDTH-1:0]   next_ptr;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    is_ready;
    logic                    write_commit;
    logic [DATA_WIDTH-1:0]   merged;
    logic [DATA_WIDTH-1:0]   init_value;
    logic [DATA_WIDTH-1:0]   read_value_1;
    logic [DATA_WIDTH-1:0]   read_value_2;

    // State and sweep pointer registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= next_state;
            ptr   <= next_ptr;
        end
    end

    // Sweep one entry per clock; leave CLEAR on the edge that writes the
    // last entry, so ready rises exactly DEPTH edges after reset drops.
    always_comb begin
        next_state = state;
        next_ptr   = ptr;
        case (state)
            CLEAR: begin
                next_ptr = ptr + ADDR_WIDTH'(1);
                if (ptr == LAST_PTR) begin
                    next_state = READY;
                end
            end
            READY: begin
                next_state = READY;
            end
            default: begin
                next_state = CLEAR;
            end
        endcase
    end

    assign is_ready = (state == READY);
    assign ready    = is_ready;

    // Byte-merged write value and the decision whether it really lands.
    // Writes to a hardwired zero entry are silently discarded.
    always_comb begin
        merged = mem[write_address];
        for (int b = 0; b < NBYTES; b++) begin
            if (write_byte_enable[b]) begin
                merged[b*8 +: 8] = write_data_in[b*8 +: 8];
            end
        end
        write_commit = is_ready && write_enable
                       && !(HARD_ZERO && (write_address == '0));
        init_value   = (ptr == SP_ADDR) ? SP_INIT : '0;
    end

    // Read values with same-cycle write bypass; the zero entry always
    // reads as zero. The debug port sees only the array itself.
    always_comb begin
        read_value_1 = mem[read_address_1];
        if (write_commit && (read_address_1 == write_address)) begin
            read_value_1 = merged;
        end
        if (HARD_ZERO && (read_address_1 == '0)) begin
            read_value_1 = '0;
        end

        read_value_2 = mem[read_address_2];
        if (write_commit && (read_address_2 == write_address)) begin
            read_value_2 = merged;
        end
        if (HARD_ZERO && (read_address_2 == '0)) begin
            read_value_2 = '0;
        end

        data_out_debug = '0;
        if (is_ready && !(HARD_ZERO && (read_address_debug == '0))) begin
            data_out_debug = mem[read_address_debug];
        end
    end

    // Array storage: the sweep owns the array in CLEAR, the write port in
    // READY. Nothing is written on a reset edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[ptr] <= init_value;
            end else if (write_commit) begin
                mem[write_address] <= merged;
            end
        end
    end

    // Registered read ports and the dropped-write flag. An all-zero byte
    // mask is a no-op, so it never counts as a refused write.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_out_1    <= '0;
            data_out_2    <= '0;
            write_dropped <= 1'b0;
        end else begin
            write_dropped <= !is_ready && write_enable && (|write_byte_enable);
            if (is_ready) begin
                data_out_1 <= read_value_1;
                data_out_2 <= read_value_2;
            end else begin
                data_out_1 <= '0;
                data_out_2 <= '0;
            end
        end
    end

endmodule
